// File: rtl/nec_prefetch.sv
// Instruction prefetch queue: 8-byte ring of code bytes fed by 16-bit bus fetches.
// Valid bytes occupy [decode_pc, fetch_ptr); each byte lives in slot addr[2:0].
module nec_prefetch (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_1,
  input  logic             ce_2,
  input  logic             set_pc,
  input  logic [15:0]      new_pc,
  input  logic [15:0]      decode_pc,
  output logic [7:0][7:0]  ipq,
  output logic [3:0]       ipq_len,
  output logic             bus_req,
  output logic [15:0]      bus_addr,
  input  logic             bus_ack,
  input  logic [15:0]      bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  state_t      state, state_nx;
  logic [15:0] fetch_ptr, fetch_ptr_nx, addr_nx, len_full;
  logic [2:0]  slot, slot_hi;
  logic        ce, room, wr_pair, wr_odd;

  assign ce       = ce_1 | ce_2;
  assign len_full = fetch_ptr - decode_pc;
  assign ipq_len  = len_full[3:0];
  assign slot     = fetch_ptr[2:0];
  assign slot_hi  = slot + 3'd1;
  assign bus_req  = (state != IDLE);

  // An odd fetch pointer only takes the high byte of the word, so one free slot suffices.
  assign room = fetch_ptr[0] ? (ipq_len <= 4'd7) : (ipq_len <= 4'd6);

  always_comb begin
    state_nx     = state;
    fetch_ptr_nx = fetch_ptr;
    addr_nx      = bus_addr;
    wr_pair      = 1'b0;
    wr_odd       = 1'b0;
    case (state)
      IDLE: begin
        if (set_pc) begin
          fetch_ptr_nx = new_pc;
        end else if (room) begin
          state_nx = REQ;
          addr_nx  = {fetch_ptr[15:1], 1'b0};
        end
      end
      REQ: begin
        if (set_pc) begin
          fetch_ptr_nx = new_pc;
          state_nx     = bus_ack ? IDLE : DRAIN;
        end else if (bus_ack) begin
          state_nx = IDLE;
          if (fetch_ptr[0]) begin
            wr_odd       = 1'b1;
            fetch_ptr_nx = fetch_ptr + 16'd1;
          end else begin
            wr_pair      = 1'b1;
            fetch_ptr_nx = fetch_ptr + 16'd2;
          end
        end
      end
      DRAIN: begin
        // The in-flight word belongs to the old stream; wait it out and drop it.
        if (set_pc)  fetch_ptr_nx = new_pc;
        if (bus_ack) state_nx     = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      fetch_ptr <= 16'h0000;
      bus_addr  <= 16'h0000;
    end else if (ce) begin
      state     <= state_nx;
      fetch_ptr <= fetch_ptr_nx;
      bus_addr  <= addr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ipq <= '0;
    end else if (ce) begin
      if (wr_pair) begin
        ipq[slot]    <= bus_rdata[7:0];
        ipq[slot_hi] <= bus_rdata[15:8];
      end else if (wr_odd) begin
        ipq[slot] <= bus_rdata[15:8];
      end
    end
  end

endmodule

// File: tb/tb_nec_prefetch.sv
// Bench for nec_prefetch: directed scenarios plus randomized traffic checked
// against a byte-addressed model of the code stream.
module tb_nec_prefetch;

  logic            clk = 1'b0;
  logic            reset_n, ce_1, ce_2, set_pc, bus_ack;
  logic [15:0]     new_pc, decode_pc, bus_rdata, bus_addr;
  logic [7:0][7:0] ipq;
  logic [3:0]      ipq_len;
  logic            bus_req;

  nec_prefetch dut (
    .clk(clk), .reset_n(reset_n), .ce_1(ce_1), .ce_2(ce_2), .set_pc(set_pc),
    .new_pc(new_pc), .decode_pc(decode_pc), .ipq(ipq), .ipq_len(ipq_len),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Model: a fetch pointer, one outstanding transaction, and the bytes seen per address.
  logic [15:0] m_fptr = 16'h0;
  logic [15:0] m_addr = 16'h0;
  bit          m_busy = 1'b0;
  bit          m_discard = 1'b0;
  logic [7:0]  amem [0:65535];
  bit          follow = 1'b1;
  bit          win_ok = 1'b1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [15:0] len, nxt;
    if (!reset_n) begin
      m_fptr = 16'h0; m_addr = 16'h0; m_busy = 1'b0; m_discard = 1'b0;
    end else if (ce_1 | ce_2) begin
      if (m_busy) begin
        if (bus_ack) begin
          if (!m_discard && !set_pc) begin
            nxt = m_fptr + 16'd1;
            if (m_fptr[0]) begin
              amem[m_fptr] = bus_rdata[15:8];
              m_fptr = m_fptr + 16'd1;
            end else begin
              amem[m_fptr] = bus_rdata[7:0];
              amem[nxt]    = bus_rdata[15:8];
              m_fptr = m_fptr + 16'd2;
            end
          end
          if (set_pc) m_fptr = new_pc;
          m_busy = 1'b0;
        end else if (set_pc) begin
          m_fptr = new_pc;
          m_discard = 1'b1;
        end
      end else if (set_pc) begin
        m_fptr = new_pc;
      end else begin
        len = m_fptr - decode_pc;
        if (int'(len) <= 8 - (m_fptr[0] ? 1 : 2)) begin
          m_busy = 1'b1; m_discard = 1'b0; m_addr = m_fptr & 16'hFFFE;
        end
      end
    end
  endtask

  task automatic step();
    logic [15:0] d, a;
    @(posedge clk);
    model_edge();
    #1;
    if (follow && set_pc && (ce_1 | ce_2) && reset_n) decode_pc = new_pc;
    if (!reset_n) decode_pc = 16'h0;
    #1;
    check("bus_req", bus_req, m_busy);
    if (m_busy) check("bus_addr", bus_addr, m_addr);
    d = m_fptr - decode_pc;
    check("ipq_len", ipq_len, d[3:0]);
    if (win_ok && d <= 16'd8)
      for (int i = 0; i < int'(d); i++) begin
        a = decode_pc + 16'(i);
        check("ipq_byte", ipq[a[2:0]], amem[a]);
      end
  endtask

  initial begin
    logic [15:0] w33 [4];
    logic [15:0] addrs [8];
    logic [15:0] len;
    int nacks, k;
    w33 = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    // Reset wins over set_pc and idle phase enables.
    reset_n = 1'b0; ce_1 = 1'b0; ce_2 = 1'b0; set_pc = 1'b1; new_pc = 16'h5555;
    decode_pc = 16'h0; bus_ack = 1'b0; bus_rdata = 16'h0;
    step();
    check("rst_ipq", ipq, 64'h0);
    check("rst_bus_addr", bus_addr, 16'h0);
    check("rst_bus_req", bus_req, 1'b0);
    reset_n = 1'b1; set_pc = 1'b0; ce_1 = 1'b1;

    // Fill from 0 acking every request.
    nacks = 0;
    for (int c = 0; c < 20; c++) begin
      bus_ack = bus_req;
      bus_rdata = w33[nacks & 3];
      if (bus_ack) begin
        if (nacks < 8) addrs[nacks] = bus_addr;
        nacks++;
      end
      step();
      if (ipq_len > 4'd6) check("no_req_full", bus_req, 1'b0);
    end
    bus_ack = 1'b0;
    check("fill_acks", nacks, 4);
    for (int i = 0; i < 4; i++) check("fill_addr", addrs[i], 16'(2 * i));
    check("fill_len", ipq_len, 4'd8);
    check("fill_ipq0", ipq[0], 8'h34);
    check("fill_ipq1", ipq[1], 8'h12);
    check("fill_ipq7", ipq[7], 8'hDE);

    // Odd flush target fetches only the high byte.
    set_pc = 1'b1; new_pc = 16'h0103; step(); set_pc = 1'b0;
    step();
    check("odd_addr", bus_addr, 16'h0102);
    bus_ack = 1'b1; bus_rdata = 16'hAB00; step();
    check("odd_slot3", ipq[3], 8'hAB);
    check("odd_len", ipq_len, 4'd1);
    bus_ack = 1'b0; step();
    check("odd_next_addr", bus_addr, 16'h0104);
    bus_ack = 1'b1; bus_rdata = 16'h7766; step(); bus_ack = 1'b0;

    // Flush while a request is outstanding; ack arrives 3 ce cycles later.
    set_pc = 1'b1; new_pc = 16'h0010; step(); set_pc = 1'b0;
    step();
    check("drain_req_addr", bus_addr, 16'h0010);
    set_pc = 1'b1; new_pc = 16'h0040; step(); set_pc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("drain_hold_addr", bus_addr, 16'h0010);
      check("drain_hold_req", bus_req, 1'b1);
    end
    bus_ack = 1'b1; bus_rdata = 16'hBEEF; step();
    check("drain_len", ipq_len, 4'd0);
    check("drain_req_low", bus_req, 1'b0);
    bus_ack = 1'b0; step();
    check("drain_next_addr", bus_addr, 16'h0040);
    bus_ack = 1'b1; bus_rdata = 16'h0F0E; step(); bus_ack = 1'b0;

    // Pointer wrap at 0xFFFF.
    set_pc = 1'b1; new_pc = 16'hFFFE; step(); set_pc = 1'b0;
    nacks = 0;
    for (int c = 0; c < 12 && nacks < 2; c++) begin
      bus_ack = bus_req;
      bus_rdata = (nacks == 0) ? 16'h2211 : 16'h4433;
      if (bus_ack) nacks++;
      step();
    end
    check("wrap_acks", nacks, 2);
    check("wrap_slot6", ipq[6], 8'h11);
    check("wrap_slot7", ipq[7], 8'h22);
    check("wrap_slot0", ipq[0], 8'h33);
    check("wrap_slot1", ipq[1], 8'h44);
    check("wrap_len", ipq_len, 4'd4);

    // Phase enables low: ack ignored, nothing moves.
    ce_1 = 1'b0; bus_ack = 1'b1; bus_rdata = 16'hFFFF;
    for (int c = 0; c < 4; c++) begin
      step();
      check("noce_len", ipq_len, 4'd4);
      check("noce_req", bus_req, 1'b0);
      check("noce_slot6", ipq[6], 8'h11);
      check("noce_slot1", ipq[1], 8'h44);
    end
    ce_1 = 1'b1; bus_ack = 1'b0; step();
    check("wrap_next_addr", bus_addr, 16'h0002);

    // Reset abandons the request; an ack right after release is ignored.
    reset_n = 1'b0; step();
    check("midrst_ipq", ipq, 64'h0);
    reset_n = 1'b1; bus_ack = 1'b1; bus_rdata = 16'hA5A5; step();
    check("midrst_len", ipq_len, 4'd0);
    check("midrst_ipq2", ipq, 64'h0);
    check("midrst_addr", bus_addr, 16'h0000);
    step(); bus_ack = 1'b0;

    // Full queue at odd fetch pointer; decoder frees one byte.
    set_pc = 1'b1; new_pc = 16'h0209; follow = 1'b0; win_ok = 1'b0; step();
    set_pc = 1'b0; decode_pc = 16'h0201;
    step(); step();
    check("full_odd_len", ipq_len, 4'd8);
    check("full_odd_noreq", bus_req, 1'b0);
    decode_pc = 16'h0202; step();
    check("full_odd_addr", bus_addr, 16'h0208);
    bus_ack = 1'b1; bus_rdata = 16'hCD5A; step(); bus_ack = 1'b0;
    check("full_odd_slot1", ipq[1], 8'hCD);
    check("full_odd_len2", ipq_len, 4'd8);
    step(); step();
    check("full_odd_single", bus_req, 1'b0);
    follow = 1'b1;
    set_pc = 1'b1; new_pc = 16'h3000; step(); set_pc = 1'b0; win_ok = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 2500; c++) begin
      reset_n   = ($urandom_range(0, 299) != 0);
      ce_1      = ($urandom_range(0, 9) < 6);
      ce_2      = ($urandom_range(0, 9) < 3);
      bus_ack   = bus_req ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
      bus_rdata = 16'($urandom);
      set_pc    = ($urandom_range(0, 39) == 0);
      new_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
      step();
      len = m_fptr - decode_pc;
      if (len <= 16'd8) begin
        k = $urandom_range(0, (int'(len) < 3) ? int'(len) : 3);
        decode_pc = decode_pc + 16'(k);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nec_prefetch.md
NEC_PREFETCH -- requirements
Module: nec_prefetch

Interface
REQ-001 Parameter: none; queue depth fixed at 8 bytes, bus width fixed at 16 bits.
REQ-002 clk  input  1  system clock; one clock; all state updates on posedge clk.
REQ-003 reset_n  input  1  synchronous, active-low reset; sampled on posedge clk.
REQ-004 ce_1, ce_2  input  1 each  phase enables; state advances only in cycles where ce_1|ce_2.
REQ-005 set_pc  input  1  flush request, same signal the decoder receives.
REQ-006 new_pc  input  16  new fetch offset on flush.
REQ-007 decode_pc  input  16  decoder's current pc (next byte it will consume).
REQ-008 ipq  output  8x8  queue storage; byte at offset A held in slot A[2:0].
REQ-009 ipq_len  output  4  valid bytes starting at decode_pc, range 0..8.
REQ-010 bus_req  output  1  code-fetch request.
REQ-011 bus_addr  output  16  word-aligned fetch offset, bit 0 always 0.
REQ-012 bus_ack  input  1  request accepted and data present this cycle.
REQ-013 bus_rdata  input  16  fetched word, low byte = even address.

Function
REQ-014 Internal fetch_ptr (16 bit) = offset of next byte to enter queue; valid bytes occupy [decode_pc, fetch_ptr), modulo 2^16.
REQ-015 ipq_len shall be (fetch_ptr - decode_pc) truncated to 4 bits, registered-state derived, combinational from fetch_ptr and decode_pc.
REQ-016 States: IDLE, REQ, DRAIN.
REQ-017 IDLE -> REQ when ce and no set_pc and free space sufficient: 8 - ipq_len >= 2 if fetch_ptr[0]=0, >= 1 if fetch_ptr[0]=1; drives bus_req=1, bus_addr={fetch_ptr[15:1],1'b0}.
REQ-018 In REQ, bus_req and bus_addr shall stay stable until bus_ack sampled high in a ce cycle.
REQ-019 REQ + bus_ack, aligned fetch_ptr: slot fetch_ptr[2:0] <= rdata[7:0], slot fetch_ptr[2:0]+1 (mod 8) <= rdata[15:8], fetch_ptr += 2, bus_req <= 0, -> IDLE.
REQ-020 REQ + bus_ack, odd fetch_ptr: slot fetch_ptr[2:0] <= rdata[15:8] only, fetch_ptr += 1, -> IDLE.
REQ-021 Earliest new request one ce cycle after ack (bus_req low for at least one ce cycle between fetches).
REQ-022 set_pc in IDLE: fetch_ptr <= new_pc; ipq_len reads 0 once decoder pc also equals new_pc.
REQ-023 set_pc in REQ: fetch_ptr <= new_pc, -> DRAIN; bus_req/bus_addr held unchanged until bus_ack.
REQ-024 DRAIN + bus_ack: data discarded, no slot written, fetch_ptr unchanged, bus_req <= 0, -> IDLE.
REQ-025 set_pc in DRAIN: fetch_ptr <= new_pc, remain DRAIN.
REQ-026 set_pc and bus_ack same cycle in REQ: ack data discarded, fetch_ptr <= new_pc, -> IDLE.
REQ-027 fetch_ptr arithmetic wraps 0xFFFF -> 0x0000; slot indices wrap mod 8.
REQ-028 Decoder consumption concurrent with ack: space check uses ipq_len at request issue; consumption only enlarges space, never overflow.
REQ-029 Slots outside [decode_pc, fetch_ptr) hold don't-care values; slots inside shall never be overwritten.
REQ-030 Cycles with ce_1=ce_2=0: no state change, bus_ack ignored.

Reset
REQ-031 reset_n=0 at posedge clk, regardless of ce or set_pc: state IDLE, fetch_ptr=0, bus_req=0, bus_addr=0, all ipq slots 0x00.
REQ-032 Reset mid-REQ/DRAIN abandons transaction; bus_ack in the cycle after reset release with state IDLE is ignored.

Verification
REQ-033 Reset, decode_pc=0, ack every request with rdata=0x1234,0x5678,... -> bus_addr 0,2,4,6; ipq_len 8; ipq[0]=0x34, ipq[1]=0x12; no request while ipq_len>6.
REQ-034 set_pc new_pc=0x0103 in IDLE, ack rdata=0xAB00 -> bus_addr=0x0102, slot 3 = 0xAB, fetch_ptr=0x0104, next bus_addr=0x0104.
REQ-035 set_pc new_pc=0x0040 while REQ at 0x0010 with ack delayed 3 ce cycles -> bus_addr stays 0x0010 until ack, data discarded, next request bus_addr=0x0040.
REQ-036 fetch_ptr=0xFFFE, decode_pc=0xFFFE, ack 0x2211 then 0x4433 -> slots 6,7 = 0x11,0x22; slots 0,1 = 0x33,0x44; fetch_ptr=0x0002; ipq_len=4.
REQ-037 Queue full (ipq_len=8), decoder advances decode_pc by 1 at odd fetch_ptr -> single request, one byte written, ipq_len returns to 8.
REQ-038 Hold ce_1=ce_2=0 with bus_ack=1 for 4 cycles -> no state, fetch_ptr, or ipq change.
